// File: rtl/amm_demux_pkg.sv
// Shared types and decode helpers for the Avalon-MM address demultiplexer.
package amm_demux_pkg;

  localparam int unsigned MAX_SLV = 16;

  typedef int unsigned win_arr_t [MAX_SLV];

  // Width of an index that can name n slaves plus the dummy slot.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Lowest-index window containing addr wins; no match returns n (dummy).
  function automatic int unsigned decode_slave(input logic [63:0] addr,
                                               input win_arr_t    bases,
                                               input win_arr_t    spans,
                                               input int unsigned n);
    int unsigned idx;
    logic        found;
    logic [63:0] lo;
    logic [63:0] hi;
    idx   = n;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SLV; i++) begin
      lo = 64'(bases[i]);
      hi = lo + 64'(spans[i]);
      if (!found && (i < n) && (addr >= lo) && (addr < hi)) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/amm_dummy_slave.sv
// Responder for unmapped accesses: one-cycle read reply and a saturating decode-error count.
module amm_dummy_slave #(
  parameter int unsigned     DATA_W     = 16,
  parameter longint unsigned DUMMY_DATA = 'hFFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_acc_i,
  input  logic              wr_acc_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [15:0]       decerr_cnt_o
);

  logic        rsp_valid_q;
  logic        rsp_valid_d;
  logic [15:0] decerr_q;
  logic [15:0] decerr_d;

  always_comb begin
    rsp_valid_d = rd_acc_i;
    decerr_d    = decerr_q;
    if ((rd_acc_i || wr_acc_i) && (decerr_q != '1)) begin
      decerr_d = decerr_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      decerr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      decerr_q    <= decerr_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_valid_q ? DATA_W'(DUMMY_DATA) : '0;
  assign decerr_cnt_o = decerr_q;

endmodule

// File: rtl/amm_demux_pipe.sv
// Avalon-MM 1-to-N address demultiplexer; read responses are steered by the
// slave that owns the outstanding reads, not by the current address.
module amm_demux_pipe
  import amm_demux_pkg::*;
#(
  parameter int unsigned     SLV_CNT            = 2,
  parameter int unsigned     ADDR_W             = 32,
  parameter int unsigned     DATA_W             = 16,
  parameter int              SLV_BASE [SLV_CNT] = '{0, 'h100},
  parameter int              SLV_SPAN [SLV_CNT] = '{'h100, 'h100},
  parameter int unsigned     MAX_PEND           = 4,
  parameter longint unsigned DUMMY_DATA         = 'hFFFF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ADDR_W-1:0]               mst_address_i,
  input  logic                            mst_read_i,
  input  logic                            mst_write_i,
  input  logic [DATA_W-1:0]               mst_writedata_i,
  output logic                            mst_waitrequest_o,
  output logic                            mst_readdatavalid_o,
  output logic [DATA_W-1:0]               mst_readdata_o,
  output logic [SLV_CNT-1:0][ADDR_W-1:0]  slv_address_o,
  output logic [SLV_CNT-1:0]              slv_read_o,
  output logic [SLV_CNT-1:0]              slv_write_o,
  output logic [SLV_CNT-1:0][DATA_W-1:0]  slv_writedata_o,
  input  logic [SLV_CNT-1:0]              slv_waitrequest_i,
  input  logic [SLV_CNT-1:0]              slv_readdatavalid_i,
  input  logic [SLV_CNT-1:0][DATA_W-1:0]  slv_readdata_i,
  output logic [15:0]                     decerr_cnt_o,
  output logic                            unexp_rsp_o
);

  localparam int unsigned      SEL_W  = idx_width(SLV_CNT);
  localparam int unsigned      PEND_W = idx_width(MAX_PEND);
  localparam logic [SEL_W-1:0] DUMMY  = SEL_W'(SLV_CNT);

  function automatic win_arr_t pad_win(input int arr [SLV_CNT]);
    win_arr_t r;
    for (int unsigned i = 0; i < MAX_SLV; i++) r[i] = 0;
    for (int unsigned i = 0; i < SLV_CNT; i++) r[i] = unsigned'(arr[i]);
    return r;
  endfunction

  localparam win_arr_t BASES = pad_win(SLV_BASE);
  localparam win_arr_t SPANS = pad_win(SLV_SPAN);

  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  rd_slv_q;
  logic [SEL_W-1:0]  rd_slv_d;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              unexp_q;
  logic              unexp_d;
  logic              blk;
  logic              ws;
  logic              rd_acc;
  logic              wr_acc;
  logic              exp_rsp;
  logic [SLV_CNT:0]  vld_all;
  logic [SLV_CNT:0]  exp_mask;
  logic              dummy_rd;
  logic              dummy_wr;
  logic              dummy_vld;
  logic [DATA_W-1:0] dummy_data;

  always_comb begin
    sel = SEL_W'(decode_slave(64'(mst_address_i), BASES, SPANS, SLV_CNT));
  end

  always_comb begin
    ws = 1'b0;
    for (int unsigned i = 0; i < SLV_CNT; i++) begin
      if (sel == SEL_W'(i)) ws = slv_waitrequest_i[i];
    end
    // blk looks only at the registered count, so a response arriving while
    // full does not free a slot until the next cycle.
    blk = (pend_q == PEND_W'(MAX_PEND)) || ((pend_q != '0) && (sel != rd_slv_q));
    mst_waitrequest_o = ws | (mst_read_i & blk);
    rd_acc   = mst_read_i & ~mst_waitrequest_o;
    wr_acc   = mst_write_i & ~mst_read_i & ~mst_waitrequest_o;
    dummy_rd = rd_acc && (sel == DUMMY);
    dummy_wr = wr_acc && (sel == DUMMY);
    for (int unsigned i = 0; i < SLV_CNT; i++) begin
      slv_address_o[i]   = mst_address_i;
      slv_writedata_o[i] = mst_writedata_i;
      slv_read_o[i]      = mst_read_i && (sel == SEL_W'(i)) && !blk;
      slv_write_o[i]     = mst_write_i && (sel == SEL_W'(i));
    end
  end

  // Dummy valid occupies the top bit so one mask separates expected from stray responses.
  always_comb begin
    vld_all = {dummy_vld, slv_readdatavalid_i};
    for (int unsigned i = 0; i <= SLV_CNT; i++) begin
      exp_mask[i] = (pend_q != '0) && (rd_slv_q == SEL_W'(i));
    end
    exp_rsp = |(vld_all & exp_mask);
    unexp_d = |(vld_all & ~exp_mask);
    mst_readdatavalid_o = exp_rsp;
    mst_readdata_o      = '0;
    if (exp_rsp) begin
      if (rd_slv_q == DUMMY) begin
        mst_readdata_o = dummy_data;
      end else begin
        for (int unsigned i = 0; i < SLV_CNT; i++) begin
          if (rd_slv_q == SEL_W'(i)) mst_readdata_o = slv_readdata_i[i];
        end
      end
    end
  end

  always_comb begin
    rd_slv_d = rd_acc ? sel : rd_slv_q;
    pend_d   = pend_q;
    if (rd_acc && !exp_rsp) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!rd_acc && exp_rsp) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_slv_q <= '0;
      pend_q   <= '0;
      unexp_q  <= 1'b0;
    end else begin
      rd_slv_q <= rd_slv_d;
      pend_q   <= pend_d;
      unexp_q  <= unexp_d;
    end
  end

  assign unexp_rsp_o = unexp_q;

  amm_dummy_slave #(
    .DATA_W     (DATA_W),
    .DUMMY_DATA (DUMMY_DATA)
  ) u_dummy (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_acc_i     (dummy_rd),
    .wr_acc_i     (dummy_wr),
    .rsp_valid_o  (dummy_vld),
    .rsp_data_o   (dummy_data),
    .decerr_cnt_o (decerr_cnt_o)
  );

  // Simultaneous read and write from the master is illegal.
  a_no_rd_wr: assert property (@(posedge clk_i) disable iff (rst_i)
                               !(mst_read_i && mst_write_i));

endmodule

// File: tb/tb_amm_demux_pipe.sv
// Directed bench for amm_demux_pipe with the default two-slave memory map.
module tb_amm_demux_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       addr;
  logic              rd;
  logic              wr;
  logic [15:0]       wdata;
  logic              wait_o;
  logic              rdv_o;
  logic [15:0]       rdata_o;
  logic [1:0][31:0]  s_addr;
  logic [1:0]        s_rd;
  logic [1:0]        s_wr;
  logic [1:0][15:0]  s_wdata;
  logic [1:0]        s_wait;
  logic [1:0]        s_rdv;
  logic [1:0][15:0]  s_rdata;
  logic [15:0]       decerr;
  logic              unexp;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  amm_demux_pipe #(
    .SLV_CNT    (2),
    .ADDR_W     (32),
    .DATA_W     (16),
    .MAX_PEND   (4),
    .DUMMY_DATA ('hFFFF)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .mst_address_i       (addr),
    .mst_read_i          (rd),
    .mst_write_i         (wr),
    .mst_writedata_i     (wdata),
    .mst_waitrequest_o   (wait_o),
    .mst_readdatavalid_o (rdv_o),
    .mst_readdata_o      (rdata_o),
    .slv_address_o       (s_addr),
    .slv_read_o          (s_rd),
    .slv_write_o         (s_wr),
    .slv_writedata_o     (s_wdata),
    .slv_waitrequest_i   (s_wait),
    .slv_readdatavalid_i (s_rdv),
    .slv_readdata_i      (s_rdata),
    .decerr_cnt_o        (decerr),
    .unexp_rsp_o         (unexp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = 16'h1357;
    s_wait = '0; s_rdv = '0;
    s_rdata[0] = 16'hA5A5; s_rdata[1] = 16'h5A5A;
    repeat (2) tick;
    #2;
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got %b want 0", wait_o); end
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL reset_rdv: got %b want 0", rdv_o); end
    n_cmp++; if (rdata_o !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata_o); end
    n_cmp++; if (decerr !== 16'h0) begin n_bad++; $display("FAIL reset_decerr: got %h want 0000", decerr); end
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL reset_unexp: got %b want 0", unexp); end
    s_rdv = 2'b11; #1;
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL reset_rdv_blocked: got %b want 0", rdv_o); end
    s_rdv = 2'b00;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    addr = 32'h10; rd = 1'b1; wdata = 16'hC0DE; #2;
    n_cmp++; if (s_rd !== 2'b01) begin n_bad++; $display("FAIL basic_s0_rd: got %b want 01", s_rd); end
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL basic_s0_wait: got %b want 0", wait_o); end
    n_cmp++; if (s_addr[1] !== 32'h10 || s_wdata[1] !== 16'hC0DE) begin n_bad++; $display("FAIL basic_bcast: got %h/%h want 00000010/c0de", s_addr[1], s_wdata[1]); end
    tick;
    rd = 1'b0; #2;
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL basic_s0_early: got %b want 0", rdv_o); end
    tick;
    s_rdv = 2'b01; #2;
    n_cmp++; if (rdv_o !== 1'b1) begin n_bad++; $display("FAIL basic_s0_rdv: got %b want 1", rdv_o); end
    n_cmp++; if (rdata_o !== 16'hA5A5) begin n_bad++; $display("FAIL basic_s0_data: got %h want a5a5", rdata_o); end
    tick;
    s_rdv = 2'b00; #2;
    n_cmp++; if (rdata_o !== 16'h0) begin n_bad++; $display("FAIL basic_idle_data: got %h want 0000", rdata_o); end
    tick;
    addr = 32'h120; rd = 1'b1; s_wait = 2'b10; #2;
    n_cmp++; if (wait_o !== 1'b1) begin n_bad++; $display("FAIL basic_s1_stall: got %b want 1", wait_o); end
    n_cmp++; if (s_rd !== 2'b10) begin n_bad++; $display("FAIL basic_s1_rd: got %b want 10", s_rd); end
    tick;
    s_wait = 2'b00; #2;
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL basic_s1_go: got %b want 0", wait_o); end
    tick;
    rd = 1'b0;
    tick;
    s_rdata[1] = 16'h1234; s_rdv = 2'b10; #2;
    n_cmp++; if (rdv_o !== 1'b1) begin n_bad++; $display("FAIL basic_s1_rdv: got %b want 1", rdv_o); end
    n_cmp++; if (rdata_o !== 16'h1234) begin n_bad++; $display("FAIL basic_s1_data: got %h want 1234", rdata_o); end
    tick;
    s_rdv = 2'b00;
  endtask

  task automatic test_max_pend;
    logic        exp_w;
    logic        exp_v;
    logic [15:0] exp_d;
    addr = 32'h180;
    for (int c = 0; c <= 10; c++) begin
      rd = (c <= 7);
      s_rdv[1] = (c >= 6);
      s_rdata[1] = 16'h0100 + 16'(c);
      #2;
      exp_w = (c >= 4) && (c <= 6);
      exp_v = (c >= 6);
      exp_d = exp_v ? (16'h0100 + 16'(c)) : 16'h0000;
      if (c <= 7) begin
        n_cmp++; if (wait_o !== exp_w) begin n_bad++; $display("FAIL maxpend_wait c%0d: got %b want %b", c, wait_o, exp_w); end
        n_cmp++; if (s_rd !== (exp_w ? 2'b00 : 2'b10)) begin n_bad++; $display("FAIL maxpend_srd c%0d: got %b want %b", c, s_rd, !exp_w); end
      end
      n_cmp++; if (rdv_o !== exp_v) begin n_bad++; $display("FAIL maxpend_rdv c%0d: got %b want %b", c, rdv_o, exp_v); end
      n_cmp++; if (rdata_o !== exp_d) begin n_bad++; $display("FAIL maxpend_data c%0d: got %h want %h", c, rdata_o, exp_d); end
      tick;
    end
    rd = 1'b0; s_rdv = 2'b00; #2;
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL maxpend_unexp: got %b want 0", unexp); end
    tick;
  endtask

  task automatic test_order;
    addr = 32'h10; rd = 1'b1; #2;
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL order_first_wait: got %b want 0", wait_o); end
    tick;
    addr = 32'h120; #2;
    n_cmp++; if (wait_o !== 1'b1) begin n_bad++; $display("FAIL order_block_wait: got %b want 1", wait_o); end
    n_cmp++; if (s_rd !== 2'b00) begin n_bad++; $display("FAIL order_block_srd: got %b want 00", s_rd); end
    tick;
    s_rdata[0] = 16'hAAAA; s_rdata[1] = 16'hBBBB; s_rdv = 2'b01; #2;
    n_cmp++; if (wait_o !== 1'b1) begin n_bad++; $display("FAIL order_rsp_wait: got %b want 1", wait_o); end
    n_cmp++; if (rdv_o !== 1'b1 || rdata_o !== 16'hAAAA) begin n_bad++; $display("FAIL order_rsp0: got %b/%h want 1/aaaa", rdv_o, rdata_o); end
    tick;
    s_rdv = 2'b00; #2;
    n_cmp++; if (wait_o !== 1'b0 || s_rd !== 2'b10) begin n_bad++; $display("FAIL order_second_go: got %b/%b want 0/10", wait_o, s_rd); end
    tick;
    rd = 1'b0;
    tick;
    s_rdv = 2'b10; #2;
    n_cmp++; if (rdv_o !== 1'b1 || rdata_o !== 16'hBBBB) begin n_bad++; $display("FAIL order_rsp1: got %b/%h want 1/bbbb", rdv_o, rdata_o); end
    tick;
    s_rdv = 2'b00; #2;
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL order_unexp: got %b want 0", unexp); end
    tick;
  endtask

  task automatic test_dummy;
    addr = 32'h300; rd = 1'b1; #2;
    n_cmp++; if (wait_o !== 1'b0 || s_rd !== 2'b00) begin n_bad++; $display("FAIL dummy_rd0: got %b/%b want 0/00", wait_o, s_rd); end
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL dummy_rdv0: got %b want 0", rdv_o); end
    tick;
    #2;
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL dummy_rd1_wait: got %b want 0", wait_o); end
    n_cmp++; if (rdv_o !== 1'b1 || rdata_o !== 16'hFFFF) begin n_bad++; $display("FAIL dummy_rsp1: got %b/%h want 1/ffff", rdv_o, rdata_o); end
    tick;
    rd = 1'b0; #2;
    n_cmp++; if (rdv_o !== 1'b1 || rdata_o !== 16'hFFFF) begin n_bad++; $display("FAIL dummy_rsp2: got %b/%h want 1/ffff", rdv_o, rdata_o); end
    n_cmp++; if (decerr !== 16'd2) begin n_bad++; $display("FAIL dummy_decerr2: got %0d want 2", decerr); end
    tick;
    addr = 32'h200; wr = 1'b1; s_wait = 2'b11; #2;
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL dummy_rsp_end: got %b want 0", rdv_o); end
    n_cmp++; if (wait_o !== 1'b0 || s_wr !== 2'b00) begin n_bad++; $display("FAIL dummy_wr_edge: got %b/%b want 0/00", wait_o, s_wr); end
    tick;
    addr = 32'h1FF; #2;
    n_cmp++; if (wait_o !== 1'b1 || s_wr !== 2'b10) begin n_bad++; $display("FAIL wr_last_s1: got %b/%b want 1/10", wait_o, s_wr); end
    n_cmp++; if (decerr !== 16'd3) begin n_bad++; $display("FAIL dummy_decerr3: got %0d want 3", decerr); end
    tick;
    wr = 1'b0; s_wait = 2'b00; #2;
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL dummy_unexp: got %b want 0", unexp); end
    tick;
  endtask

  task automatic test_unexpected;
    addr = 32'h10; s_rdata[1] = 16'hDEAD; s_rdv = 2'b10; #2;
    n_cmp++; if (rdv_o !== 1'b0 || rdata_o !== 16'h0) begin n_bad++; $display("FAIL unexp_fwd: got %b/%h want 0/0000", rdv_o, rdata_o); end
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL unexp_early: got %b want 0", unexp); end
    tick;
    s_rdv = 2'b00; #2;
    n_cmp++; if (unexp !== 1'b1) begin n_bad++; $display("FAIL unexp_pulse: got %b want 1", unexp); end
    tick;
    #2;
    n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL unexp_once: got %b want 0", unexp); end
    tick;
  endtask

  task automatic test_reset_pending;
    addr = 32'h10; rd = 1'b1;
    tick;
    #2;
    n_cmp++; if (wait_o !== 1'b0) begin n_bad++; $display("FAIL rstp_second_wait: got %b want 0", wait_o); end
    tick;
    rd = 1'b0; s_rdata[0] = 16'h1111; s_rdv = 2'b01; #2;
    n_cmp++; if (rdv_o !== 1'b1) begin n_bad++; $display("FAIL rstp_pre_rdv: got %b want 1", rdv_o); end
    rst = 1'b1; #1;
    n_cmp++; if (rdv_o !== 1'b0 || rdata_o !== 16'h0) begin n_bad++; $display("FAIL rstp_async: got %b/%h want 0/0000", rdv_o, rdata_o); end
    n_cmp++; if (decerr !== 16'h0) begin n_bad++; $display("FAIL rstp_decerr: got %0d want 0", decerr); end
    tick;
    rst = 1'b0; #2;
    n_cmp++; if (rdv_o !== 1'b0) begin n_bad++; $display("FAIL rstp_late_fwd: got %b want 0", rdv_o); end
    tick;
    s_rdv = 2'b00; #2;
    n_cmp++; if (unexp !== 1'b1) begin n_bad++; $display("FAIL rstp_late_flag: got %b want 1", unexp); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_pend;
    test_order;
    test_dummy;
    test_unexpected;
    test_reset_pending;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
